regfile_sb: RTL and testbench

- Parametrised multi-port integer register file for the RISC-V core; successor to the single 64-bit enable register.
- Holds NREGS registers of XLEN bits, with NRD asynchronous read ports and one synchronous write port.
- Register x0 is hardwired to zero.
- A per-register busy scoreboard lets decode stall on pending writebacks.
- Sits between decode (reads and claims) and writeback (writes).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regn.sv | 23 ++
 rtl/regfile_sb.sv | 92 +++++++++
 tb/tb_regfile_sb.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and packed-port helper for the integer register file
package regfile_pkg;

   localparam int XLEN_DEF  = 64;
   localparam int NREGS_DEF = 32;
   localparam int NRD_DEF   = 2;
   localparam int REG_ZERO  = 0;

   // Low bit of port `port` in a bus packing ports of `width` bits each
   function automatic int slice_lo(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/regn.sv
// rtl/regn.sv - XLEN-wide register with synchronous clear and load enable
module regn
   import regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [XLEN-1:0] d,
   output logic [XLEN-1:0] q
);

   // Clear on reset, otherwise load when enabled
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (we) begin
         q <= d;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with busy scoreboard (optional REGFILE_BYPASS_EN write-through)
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int  XLEN  = XLEN_DEF,
   parameter int  NREGS = NREGS_DEF,
   parameter int  NRD   = NRD_DEF,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [XLEN-1:0]     wdata,
   input  logic                claim,
   input  logic [AW-1:0]       claim_addr,
   input  logic [NRD*AW-1:0]   raddr,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]      rbusy,
   output logic [NREGS-1:0]    busy_vec
);

   localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_next;
   logic             wr_ok;
   logic             claim_ok;

   assign wr_ok    = we && (waddr != ZERO_IDX);
   assign claim_ok = claim && (claim_addr != ZERO_IDX);

   // x0 is a constant, never stored
   assign regs[0] = '0;

   for (genvar n = 1; n < NREGS; n++) begin : g_reg
      logic reg_we;
      assign reg_we = wr_ok && (waddr == AW'(n));

      regn #(.XLEN(XLEN)) u_reg (
         .clk (clk),
         .rst (rst),
         .we  (reg_we),
         .d   (wdata),
         .q   (regs[n])
      );
   end

   // Next scoreboard: writeback clears, then claim sets so a new producer wins
   always_comb begin
      busy_next = busy;
      if (wr_ok) begin
         busy_next[waddr] = 1'b0;
      end
      if (claim_ok) begin
         busy_next[claim_addr] = 1'b1;
      end
      busy_next[REG_ZERO] = 1'b0;
   end

   // Scoreboard state
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   assign busy_vec = busy;

   // Asynchronous read ports with per-port busy lookup
   always_comb begin
      rdata = '0;
      rbusy = '0;
      for (int i = 0; i < NRD; i++) begin
         logic [AW-1:0] ra;
         ra = raddr[slice_lo(i, AW) +: AW];
         rdata[slice_lo(i, XLEN) +: XLEN] = regs[ra];
         rbusy[i] = busy[ra];
`ifdef REGFILE_BYPASS_EN
         // Forward the in-flight writeback; a same-cycle claim keeps it busy
         if (wr_ok && (ra == waddr)) begin
            rdata[slice_lo(i, XLEN) +: XLEN] = wdata;
            rbusy[i] = claim_ok && (claim_addr == ra);
         end
`endif
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;
   import regfile_pkg::*;

   localparam int XLEN  = XLEN_DEF;
   localparam int NREGS = NREGS_DEF;
   localparam int NRD   = NRD_DEF;
   localparam int AW    = $clog2(NREGS_DEF);

   logic                clk = 1'b0;
   logic                rst;
   logic                we;
   logic [AW-1:0]       waddr;
   logic [XLEN-1:0]     wdata;
   logic                claim;
   logic [AW-1:0]       claim_addr;
   logic [NRD*AW-1:0]   raddr;
   logic [NRD*XLEN-1:0] rdata;
   logic [NRD-1:0]      rbusy;
   logic [NREGS-1:0]    busy_vec;

   int total = 0;
   int bad   = 0;

   regfile_sb dut (
      .clk        (clk),
      .rst        (rst),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .claim      (claim),
      .claim_addr (claim_addr),
      .raddr      (raddr),
      .rdata      (rdata),
      .rbusy      (rbusy),
      .busy_vec   (busy_vec)
   );

   always #5 clk = ~clk;

   wire [XLEN-1:0] rd0 = rdata[XLEN-1:0];
   wire [XLEN-1:0] rd1 = rdata[2*XLEN-1:XLEN];

   task automatic idle();
      rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; claim = 1'b0; claim_addr = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic set_rd(input int a0, input int a1);
      raddr = {AW'(a1), AW'(a0)};
      #1;
   endtask

   task automatic do_write(input int a, input logic [XLEN-1:0] d);
      we = 1'b1; waddr = AW'(a); wdata = d;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; tick();
      do_write(2, 64'hAB);
      claim = 1'b1; claim_addr = AW'(6); tick();
      for (int c = 0; c < 2; c++) begin
         rst = 1'b1; we = 1'b1; waddr = AW'(5); wdata = 64'h1234;
         claim = 1'b1; claim_addr = AW'(8);
         tick();
      end
      set_rd(2, 5);
      total++; if (busy_vec !== '0) begin bad++; $display("FAIL reset_busy_vec got=%h exp=0", busy_vec); end
      total++; if (rd0 !== '0) begin bad++; $display("FAIL reset_x2 got=%h exp=0", rd0); end
      total++; if (rd1 !== '0) begin bad++; $display("FAIL reset_x5_discarded got=%h exp=0", rd1); end
      total++; if (rbusy !== '0) begin bad++; $display("FAIL reset_rbusy got=%b exp=0", rbusy); end
   endtask

   task automatic test_write_read();
      do_write(1, 64'h0123456789ABCDEF);
      do_write(31, 64'hA5A5A5A5A5A5A5A5);
      set_rd(1, 31);
      total++; if (rd0 !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL wr_x1 got=%h exp=0123456789abcdef", rd0); end
      total++; if (rd1 !== 64'hA5A5A5A5A5A5A5A5) begin bad++; $display("FAIL wr_x31 got=%h exp=a5a5a5a5a5a5a5a5", rd1); end
      set_rd(0, 1);
      total++; if (rd0 !== '0) begin bad++; $display("FAIL rd_x0 got=%h exp=0", rd0); end
      set_rd(31, 31);
      total++; if (rd0 !== 64'hA5A5A5A5A5A5A5A5 || rd1 !== 64'hA5A5A5A5A5A5A5A5) begin
         bad++; $display("FAIL same_index got=%h/%h exp=a5a5a5a5a5a5a5a5", rd0, rd1);
      end
   endtask

   task automatic test_x0();
      we = 1'b1; waddr = '0; wdata = '1;
      claim = 1'b1; claim_addr = '0;
      tick();
      set_rd(0, 0);
      total++; if (rd0 !== '0) begin bad++; $display("FAIL x0_write got=%h exp=0", rd0); end
      total++; if (busy_vec !== '0) begin bad++; $display("FAIL x0_claim got=%h exp=0", busy_vec); end
   endtask

   task automatic test_scoreboard();
      claim = 1'b1; claim_addr = AW'(7); tick();
      set_rd(7, 1);
      total++; if (busy_vec !== 32'h0000_0080) begin bad++; $display("FAIL claim_x7 got=%h exp=00000080", busy_vec); end
      total++; if (rbusy !== 2'b01) begin bad++; $display("FAIL rbusy_x7 got=%b exp=01", rbusy); end
      claim = 1'b1; claim_addr = AW'(7); tick();
      total++; if (busy_vec !== 32'h0000_0080) begin bad++; $display("FAIL reclaim_x7 got=%h exp=00000080", busy_vec); end
      do_write(7, 64'hDEADBEEF);
      #1;
      total++; if (busy_vec !== '0) begin bad++; $display("FAIL wb_x7_clear got=%h exp=0", busy_vec); end
      total++; if (rd0 !== 64'hDEADBEEF) begin bad++; $display("FAIL wb_x7_data got=%h exp=deadbeef", rd0); end
      total++; if (rbusy !== 2'b00) begin bad++; $display("FAIL wb_x7_rbusy got=%b exp=00", rbusy); end
      do_write(1, 64'h1111);
      total++; if (busy_vec !== '0) begin bad++; $display("FAIL wb_nonbusy got=%h exp=0", busy_vec); end
   endtask

   task automatic test_simultaneous();
      claim = 1'b1; claim_addr = AW'(9);
      we = 1'b1; waddr = AW'(9); wdata = 64'h55;
      tick();
      set_rd(9, 9);
      total++; if (busy_vec !== 32'h0000_0200) begin bad++; $display("FAIL same_claim_wins got=%h exp=00000200", busy_vec); end
      total++; if (rd0 !== 64'h55) begin bad++; $display("FAIL same_data got=%h exp=55", rd0); end
      claim = 1'b1; claim_addr = AW'(4); tick();
      claim = 1'b1; claim_addr = AW'(3);
      we = 1'b1; waddr = AW'(4); wdata = 64'h44;
      tick();
      total++; if (busy_vec !== 32'h0000_0208) begin bad++; $display("FAIL indep got=%h exp=00000208", busy_vec); end
   endtask

   task automatic test_bypass();
      set_rd(0, 12);
      we = 1'b1; waddr = AW'(12); wdata = 64'hCAFEF00D;
      #1;
`ifdef REGFILE_BYPASS_EN
      total++; if (rd1 !== 64'hCAFEF00D) begin bad++; $display("FAIL bypass_fwd got=%h exp=cafef00d", rd1); end
`else
      total++; if (rd1 !== '0) begin bad++; $display("FAIL no_bypass got=%h exp=0", rd1); end
`endif
      total++; if (rbusy[1] !== 1'b0) begin bad++; $display("FAIL bypass_rbusy got=%b exp=0", rbusy[1]); end
      tick();
      total++; if (rd1 !== 64'hCAFEF00D) begin bad++; $display("FAIL bypass_after got=%h exp=cafef00d", rd1); end
   endtask

   task automatic test_back_to_back();
      do_write(20, 64'h20);
      do_write(21, 64'h21);
      do_write(20, 64'h2020);
      set_rd(20, 21);
      total++; if (rd0 !== 64'h2020 || rd1 !== 64'h21) begin
         bad++; $display("FAIL b2b got=%h/%h exp=2020/21", rd0, rd1);
      end
   endtask

   initial begin
      idle();
      raddr = '0;
      test_reset();
      test_write_read();
      test_x0();
      test_scoreboard();
      test_simultaneous();
      test_bypass();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
